sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the number of serial bits per parallel word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 0, SHALL select bit order (0: first bit received lands in dout[0]; 1: first bit lands in dout[WIDTH-1]).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 sin  input  1  serial data bit (the serial output of the upstream parallel-to-serial stage).
REQ-006 sin_en  input  1  qualifies sin; bit sampled only when high.
REQ-007 clear  input  1  synchronous flush.
REQ-008 dout  output  WIDTH  assembled parallel word.
REQ-009 dout_valid  output  1  dout holds an unconsumed word.
REQ-010 dout_ready  input  1  downstream accepts dout.
REQ-011 overrun  output  1  sticky flag, a completed word was dropped.
REQ-012 bit_cnt  output  $clog2(WIDTH)  number of bits of the in-progress word collected so far.

Function
REQ-013 Block SHALL contain a WIDTH-bit shift register, a bit counter, and a one-entry output holding register (dout/dout_valid).
REQ-014 On a rising edge with sin_en=1 and clear=0, sin SHALL be stored at the bit position implied by bit_cnt and MSB_FIRST, and bit_cnt SHALL increment.
REQ-015 sin_en=0 SHALL leave shift register and bit_cnt unchanged (gaps between bits allowed, any length).
REQ-016 On the edge sampling bit WIDTH-1 (bit_cnt=WIDTH-1, sin_en=1), bit_cnt SHALL wrap to 0 and the word including that bit SHALL be "completed" in the same edge.
REQ-017 Completed word SHALL be loaded into dout with dout_valid=1 visible the cycle after the sampling edge (latency 1 clk from final bit) if the holding register is empty or is drained on that same edge.
REQ-018 Transfer SHALL occur on a rising edge where dout_valid=1 and dout_ready=1; dout_valid SHALL then fall unless REQ-017 loads a new word on the same edge, in which case dout_valid stays 1 and dout updates.
REQ-019 While dout_valid=1 and dout_ready=0, dout SHALL remain stable.
REQ-020 Word completing while holding register full and dout_ready=0 SHALL be discarded, dout unchanged, overrun set to 1; bit collection continues from bit_cnt=0.
REQ-021 overrun SHALL stay 1 until clear or reset.
REQ-022 dout_ready while dout_valid=0 SHALL have no effect.
REQ-023 clear=1 SHALL, on the rising edge, set bit_cnt=0, shift register=0, dout=0, dout_valid=0, overrun=0, and SHALL override sin_en and dout_ready in that cycle.
REQ-024 Back-to-back words with sin_en held high and dout_ready held high SHALL be accepted without loss at one bit per clock.

Reset
REQ-025 rst=0 SHALL immediately (without clock) force dout=0, dout_valid=0, overrun=0, bit_cnt=0, shift register=0.
REQ-026 Reset asserted mid-word SHALL discard the partial word; first sampled bit after rst rises SHALL be treated as bit 0 of a new word.
REQ-027 Release of rst SHALL take effect on the first rising edge with rst=1; no bit sampled while rst=0.

Verification (WIDTH=4, MSB_FIRST=0 unless stated)
REQ-028 sin=1,0,1,1 on 4 consecutive edges, sin_en=1, dout_ready=0 -> next cycle dout=4'hD, dout_valid=1, bit_cnt=0, overrun=0.
REQ-029 MSB_FIRST=1, same stimulus -> dout=4'hB.
REQ-030 Word 4'hD held unconsumed, then bits 0,1,0,0 sent with dout_ready=0 -> dout stays 4'hD, overrun=1; then dout_ready=1 one cycle -> dout_valid=0, overrun remains 1.
REQ-031 Continuous sin_en=1, dout_ready=1, 3 words 4'h1,4'hA,4'hF -> dout_valid pulses one cycle each, 4 clocks apart, values in order, overrun=0.
REQ-032 Bits 1,1 with sin_en gaps of 3 cycles between, then rst=0 for 1 cycle, then bits 0,0,1,0 -> dout=4'h4, no residue of earlier bits.
REQ-033 dout_valid=1 with final bit of next word and dout_ready=1 on same edge -> dout_valid stays 1, dout updates, overrun=0; clear=1 next cycle -> all outputs 0.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: collects WIDTH qualified bits into a word; word appears 1 clk after its final bit.
// One-entry valid/ready holding register; a word completing while it is full and not drained is dropped and flagged.
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sin,
  input  logic                     sin_en,
  input  logic                     clear,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    pos;
  logic             done;
  logic             load;
  logic             drop;

  // word is the shift register with the current bit merged in, so the final
  // bit can go straight to dout on the completing edge.
  always_comb begin
    pos       = MSB_FIRST ? (LAST - bit_cnt) : bit_cnt;
    word      = shreg;
    word[pos] = sin;
    done      = sin_en && (bit_cnt == LAST);
    load      = done && (!dout_valid || dout_ready);
    drop      = done && dout_valid && !dout_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sin_en) begin
        if (done) begin
          shreg   <= '0;
          bit_cnt <= '0;
        end else begin
          shreg   <= word;
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
      if (drop) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sipo_rx.sv
// Scoreboard bench for sipo_rx: LSB-first and MSB-first instances share all inputs and one word-level model.
module tb_sipo_rx;

  logic       clk;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic       clear;
  logic       dout_ready;
  logic [3:0] dout_l, dout_m;
  logic       vld_l, vld_m;
  logic       ovr_l, ovr_m;
  logic [1:0] cnt_l, cnt_m;

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clear(clear),
    .dout(dout_l), .dout_valid(vld_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clear(clear),
    .dout(dout_m), .dout_valid(vld_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model: bits of the word in progress, plus the holding register.
  int         m_bits[$];
  logic       m_vld;
  logic       m_ovr;
  logic [3:0] m_hold_l, m_hold_m;
  logic [3:0] q_l[$];
  logic [3:0] q_m[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_vld    = 1'b0;
    m_ovr    = 1'b0;
    m_hold_l = 4'h0;
    m_hold_m = 4'h0;
    q_l.delete();
    q_m.delete();
  endtask

  // Drive one cycle, then advance the model to the post-edge state.
  task automatic apply(input logic s, input logic en, input logic clr, input logic rdy);
    logic [3:0] wl, wm;
    bit         done;
    bit         accept;
    sin        = s;
    sin_en     = en;
    clear      = clr;
    dout_ready = rdy;
    @(posedge clk);
    if (clr) begin
      m_bits.delete();
      m_vld    = 1'b0;
      m_ovr    = 1'b0;
      m_hold_l = 4'h0;
      m_hold_m = 4'h0;
    end else begin
      accept = m_vld && rdy;
      done   = 1'b0;
      wl     = 4'h0;
      wm     = 4'h0;
      if (en) begin
        m_bits.push_back(int'(s));
        if (m_bits.size() == 4) begin
          for (int i = 0; i < 4; i++) begin
            wl = wl + 4'(m_bits[i] << i);
            wm = wm + 4'(m_bits[i] << (3 - i));
          end
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (accept) m_vld = 1'b0;
      if (done) begin
        if (!m_vld) begin
          m_vld    = 1'b1;
          m_hold_l = wl;
          m_hold_m = wm;
          q_l.push_back(wl);
          q_m.push_back(wm);
        end else begin
          m_ovr = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic send_word(input logic [3:0] v, input logic rdy);
    for (int i = 0; i < 4; i++) apply(v[i], 1'b1, 1'b0, rdy);
  endtask

  // Asynchronous reset held across one edge with a qualified bit that must be ignored.
  task automatic do_reset();
    rst    = 1'b0;
    sin    = 1'b1;
    sin_en = 1'b1;
    model_reset();
    #1;
    chk("rst_dout", 32'(dout_l), 0);
    chk("rst_valid", 32'(vld_l), 0);
    chk("rst_overrun", 32'(ovr_l), 0);
    chk("rst_bit_cnt", 32'(cnt_l), 0);
    @(posedge clk);
    #1;
    rst    = 1'b1;
    sin_en = 1'b0;
  endtask

  // Monitor: per-cycle state against the model, and each newly presented word against the queue.
  logic prev_vld = 1'b0;
  logic prev_acc = 1'b0;
  initial begin
    logic [3:0] el, em;
    forever begin
      @(negedge clk);
      chk("valid_l", 32'(vld_l), 32'(m_vld));
      chk("valid_m", 32'(vld_m), 32'(m_vld));
      chk("overrun_l", 32'(ovr_l), 32'(m_ovr));
      chk("overrun_m", 32'(ovr_m), 32'(m_ovr));
      chk("bit_cnt", 32'(cnt_l), 32'(m_bits.size()));
      if (vld_l) begin
        chk("hold_l", 32'(dout_l), 32'(m_hold_l));
        chk("hold_m", 32'(dout_m), 32'(m_hold_m));
        if (!prev_vld || prev_acc) begin
          if (q_l.size() == 0 || q_m.size() == 0) begin
            chk("word_queue_nonempty", 0, 1);
          end else begin
            el = q_l.pop_front();
            em = q_m.pop_front();
            chk("word_l", 32'(dout_l), 32'(el));
            chk("word_m", 32'(dout_m), 32'(em));
          end
        end
      end
      prev_vld = vld_l;
      prev_acc = vld_l && dout_ready;
    end
  end

  initial begin
    sin        = 1'b0;
    sin_en     = 1'b0;
    clear      = 1'b0;
    dout_ready = 1'b0;
    rst        = 1'b0;
    model_reset();
    #2;
    do_reset();

    // 1,0,1,1 unconsumed -> 4'hD LSB-first, 4'hB MSB-first.
    send_word(4'hD, 1'b0);
    chk("d_dout_l", 32'(dout_l), 32'hD);
    chk("d_dout_m", 32'(dout_m), 32'hB);
    chk("d_valid", 32'(vld_l), 1);
    chk("d_bit_cnt", 32'(cnt_l), 0);
    chk("d_overrun", 32'(ovr_l), 0);

    // Next word dropped while holding register is full.
    send_word(4'h2, 1'b0);
    chk("ovr_dout", 32'(dout_l), 32'hD);
    chk("ovr_flag", 32'(ovr_l), 1);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drain_valid", 32'(vld_l), 0);
    chk("ovr_sticky", 32'(ovr_l), 1);
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    chk("clr_overrun", 32'(ovr_l), 0);

    // Back-to-back words at one bit per clock with ready held high.
    send_word(4'h1, 1'b1);
    send_word(4'hA, 1'b1);
    send_word(4'hF, 1'b1);
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_overrun", 32'(ovr_l), 0);

    // Partial word with gaps, then reset: no residue.
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_word(4'h4, 1'b0);
    chk("rst_word_l", 32'(dout_l), 32'h4);
    chk("rst_word_m", 32'(dout_m), 32'h2);

    // Drain and reload on the same edge, then clear.
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    chk("reload_valid", 32'(vld_l), 1);
    chk("reload_dout", 32'(dout_l), 32'h3);
    chk("reload_overrun", 32'(ovr_l), 0);
    apply(1'b1, 1'b1, 1'b1, 1'b1);
    chk("clear_dout", 32'(dout_l), 0);
    chk("clear_valid", 32'(vld_l), 0);
    chk("clear_bit_cnt", 32'(cnt_l), 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        apply(1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 99) < 2),
              1'($urandom_range(0, 2) != 0));
      end
    end
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("words_outstanding", 32'(q_l.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
